// File: rtl/speed_ascii_formatter_pkg.sv
// Shared ASCII constants and helpers for the LCD text-field formatter.
package speed_ascii_formatter_pkg;

  localparam logic [7:0] _SPACE = 8'h20;
  localparam logic [7:0] _0     = 8'h30;
  localparam logic [7:0] _1     = 8'h31;
  localparam logic [7:0] _2     = 8'h32;
  localparam logic [7:0] _3     = 8'h33;
  localparam logic [7:0] _4     = 8'h34;
  localparam logic [7:0] _5     = 8'h35;
  localparam logic [7:0] _6     = 8'h36;
  localparam logic [7:0] _7     = 8'h37;
  localparam logic [7:0] _8     = 8'h38;
  localparam logic [7:0] _9     = 8'h39;

  // Nibbles above 9 cannot come out of a valid BCD conversion; map them to '9'.
  function automatic logic [7:0] digit_to_ascii(logic [3:0] n);
    logic [7:0] c;
    case (n)
      4'd0:    c = _0;
      4'd1:    c = _1;
      4'd2:    c = _2;
      4'd3:    c = _3;
      4'd4:    c = _4;
      4'd5:    c = _5;
      4'd6:    c = _6;
      4'd7:    c = _7;
      4'd8:    c = _8;
      default: c = _9;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/speed_ascii_formatter_if.sv
// Start/ready/valid bundle between a requester and the ASCII formatter.
interface speed_ascii_formatter_if #(
  parameter int unsigned VALUE_W = 8,
  parameter int unsigned DIGITS  = 3
);
  logic                  start;
  logic [VALUE_W-1:0]    value;
  logic                  ready;
  logic                  valid;
  logic [8*DIGITS-1:0]   ascii;
  logic                  overflow;

  modport master (
    output start, value,
    input  ready, valid, ascii, overflow
  );

  modport slave (
    input  start, value,
    output ready, valid, ascii, overflow
  );
endinterface

// File: rtl/speed_ascii_formatter_bcd_add3.sv
// Double-dabble per-nibble adjust: add 3 to any digit of 5 or more before a shift.
module speed_ascii_formatter_bcd_add3 (
  input  logic [3:0] nibble_i,
  output logic [3:0] nibble_o
);
  assign nibble_o = (nibble_i >= 4'd5) ? nibble_i + 4'd3 : nibble_i;
endmodule

// File: rtl/speed_ascii_formatter.sv
// Iterative binary-to-decimal ASCII formatter with optional leading-zero blanking.
module speed_ascii_formatter
  import speed_ascii_formatter_pkg::*;
#(
  parameter int unsigned VALUE_W       = 8,
  parameter int unsigned DIGITS        = 3,
  parameter int unsigned BLANK_LEADING = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  speed_ascii_formatter_if.slave  bus
);

  localparam int unsigned BcdW   = 4 * (DIGITS + 1);
  localparam int unsigned CntW   = $clog2(VALUE_W + 1);
  localparam int unsigned MaxVal = 10 ** DIGITS - 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] FORMAT = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [VALUE_W-1:0]  bin_q, bin_d;
  logic [BcdW-1:0]     bcd_q, bcd_d, bcd_adj;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                valid_q, valid_d;
  logic [8*DIGITS-1:0] ascii_q, ascii_d;
  logic                overflow_q, overflow_d;
  logic                unused_msb;

  // Overflow forces all '9' with no blanking; the LSD is never blanked.
  function automatic logic [8*DIGITS-1:0] format_ascii(logic [4*DIGITS-1:0] bcd, logic ovf);
    logic [8*DIGITS-1:0] s;
    logic                lead;
    s    = '0;
    lead = (BLANK_LEADING != 0);
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      if (ovf) begin
        s[8*i +: 8] = _9;
      end else if (lead && i != 0 && bcd[4*i +: 4] == 4'd0) begin
        s[8*i +: 8] = _SPACE;
      end else begin
        s[8*i +: 8] = digit_to_ascii(bcd[4*i +: 4]);
        lead        = 1'b0;
      end
    end
    return s;
  endfunction

  for (genvar g = 0; g < DIGITS + 1; g++) begin : g_adj
    speed_ascii_formatter_bcd_add3 u_add3 (
      .nibble_i (bcd_q[4*g +: 4]),
      .nibble_o (bcd_adj[4*g +: 4])
    );
  end

  // The top bit of the spare nibble is shifted out and never observed.
  assign unused_msb = bcd_adj[BcdW-1];

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;
    ascii_d    = ascii_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          bin_d   = bus.value;
          bcd_d   = '0;
          ovf_d   = 32'(bus.value) > MaxVal;
          cnt_d   = CntW'(VALUE_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = {bcd_adj[BcdW-2:0], bin_q[VALUE_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) state_d = FORMAT;
      end
      FORMAT: begin
        ascii_d    = format_ascii(bcd_q[4*DIGITS-1:0], ovf_q);
        overflow_d = ovf_q;
        valid_d    = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      ascii_q    <= format_ascii('0, 1'b0);
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
      ascii_q    <= ascii_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.ready    = (state_q == IDLE);
  assign bus.valid    = valid_q;
  assign bus.ascii    = ascii_q;
  assign bus.overflow = overflow_q;

endmodule
